// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control path.
package multicycle_control_pkg;

  // Opcode field values, common with the single-cycle decoder.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_ALU_WB_R = 4'd7,
    S_BRANCH   = 4'd8,
    S_EXEC_I   = 4'd9,
    S_ALU_WB_I = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12
  } state_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// Watchdog for memory accesses: counts consecutive stalled cycles and
// raises expire in the last allowed cycle.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic mem_ready,
  output logic expire
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Leaving a memory state always coincides with mem_ready or expire,
  // so clearing on those plus !active covers every state change.
  always_comb begin
    expire = active && !mem_ready && (cnt_q == CNT_W'(TIMEOUT - 1));
    cnt_d  = cnt_q + 1'b1;
    if (!active || mem_ready || expire) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM with memory handshake stall and watchdog.
module multicycle_control #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OP,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteEQ,
  output logic       PCWriteNE,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic [1:0] RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       illegal_op,
  output logic       bus_error,
  output logic [3:0] state
);

  import multicycle_control_pkg::*;

  state_e state_q, state_d;
  logic   bus_error_q, bus_error_d;
  logic   wait_active;
  logic   expire;

  // Ungated write enables; masked during reset below.
  logic pc_write, pc_write_eq, pc_write_ne, mem_write, ir_write, reg_write;

  // Watchdog runs only while a memory access is outstanding.
  always_comb begin
    wait_active = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                  (state_q == S_MEM_WR);
  end

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_mem_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .active    (wait_active),
    .mem_ready (mem_ready),
    .expire    (expire)
  );

  // Next-state and per-state datapath control decode.
  always_comb begin
    state_d     = state_q;
    bus_error_d = bus_error_q | expire;
    pc_write    = 1'b0;
    pc_write_eq = 1'b0;
    pc_write_ne = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = REGDST_RT;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_RT;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    illegal_op  = 1'b0;

    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMM_SH;
        case (OP)
          OP_LW, OP_SW:          state_d = S_MEM_ADDR;
          OP_RTYPE:              state_d = S_EXEC_R;
          OP_BEQ, OP_BNE:        state_d = S_BRANCH;
          OP_ADDI, OP_ORI, OP_LUI: state_d = S_EXEC_I;
          OP_J:                  state_d = S_JUMP;
          OP_JAL:                state_d = S_JAL;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        if (OP == OP_LW) begin
          state_d = S_MEM_RD;
        end else if (OP == OP_SW) begin
          state_d = S_MEM_WR;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else if (expire) begin
          state_d = S_FETCH;
        end
      end
      S_MEM_WB: begin
        reg_write = 1'b1;
        MemtoReg  = 1'b1;
        RegDst    = REGDST_RT;
        state_d   = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        IorD      = 1'b1;
        if (mem_ready || expire) begin
          state_d = S_FETCH;
        end
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_RT;
        ALUOp   = ALUOP_FUNCT;
        state_d = S_ALU_WB_R;
      end
      S_ALU_WB_R: begin
        reg_write = 1'b1;
        RegDst    = REGDST_RD;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_RT;
        ALUOp       = ALUOP_SUB;
        PCSource    = PCSRC_ALUOUT;
        pc_write_eq = (OP == OP_BEQ);
        pc_write_ne = (OP == OP_BNE);
        state_d     = S_FETCH;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ((OP == OP_ORI) || (OP == OP_LUI)) ? ALUOP_IMM : ALUOP_ADD;
        state_d = S_ALU_WB_I;
      end
      S_ALU_WB_I: begin
        reg_write = 1'b1;
        RegDst    = REGDST_RT;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        PCSource = PCSRC_JUMP;
        state_d  = S_FETCH;
      end
      S_JAL: begin
        pc_write  = 1'b1;
        PCSource  = PCSRC_JUMP;
        reg_write = 1'b1;
        RegDst    = REGDST_RA;
        state_d   = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Write enables are suppressed in any cycle where reset is asserted.
  always_comb begin
    PCWrite   = pc_write    & ~reset;
    PCWriteEQ = pc_write_eq & ~reset;
    PCWriteNE = pc_write_ne & ~reset;
    MemWrite  = mem_write   & ~reset;
    IRWrite   = ir_write    & ~reset;
    RegWrite  = reg_write   & ~reset;
    bus_error = bus_error_q;
    state     = state_q;
  end

  // State and sticky error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_error_q <= bus_error_d;
    end
  end

endmodule
